// File: rtl/cipher_pkg.sv
// Shared definitions for the cipher arbiter: core type codes, block width, owner tags.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cipher_pkg;

  localparam int DATA_W        = 128;
  localparam int TAG_DEPTH_DEF = 16;

  // Type codes on the stream towards the cipher core.
  typedef enum logic [1:0] {
    CORE_ENC = 2'b00,
    CORE_DEC = 2'b01,
    CORE_KEY = 2'b10,
    CORE_IV  = 2'b11
  } core_type_e;

  // Type codes on the result stream (core_tout / x_tout).
  localparam logic OUT_ENC = 1'b0;
  localparam logic OUT_DEC = 1'b1;

  // Owner tag stored per in-flight block.
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  typedef logic [DATA_W-1:0] block_t;

  // One beat on the core request stream.
  typedef struct packed {
    logic       vld;
    core_type_e typ;
    block_t     dat;
  } core_req_t;

  // Requester type bit (0=encrypt, 1=decrypt) to core type code.
  function automatic core_type_e req_type(input logic tin);
    return tin ? CORE_DEC : CORE_ENC;
  endfunction

endpackage

// File: rtl/cipher_arbiter_tag_fifo.sv
// Owner-tag FIFO: 1-bit wide, DEPTH deep, records which requester owns each in-flight block.
// Latency: push visible on dout/count the cycle after; dout is the head entry, read combinationally.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keep count.
// Ports: clk/rst (async active-high), push/din, pop/dout, full, empty, count.
module tag_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cipher_arbiter.sv
// Arbitrates requesters A/B and IV loads onto one cipher core and routes results back by owner tag.
// Latency: grant -> core_vin 1 cycle; core_vout -> a/b_vout 1 cycle.
// Backpressure: combinational rdy per source; no result backpressure; IV load drains in-flight blocks first.
// Ports: clk, rst; crypto_ready; a_*/b_* requester in/out streams; cfg_* IV load;
//        core_vin/tin/din to core; core_vout/tout/dout from core; err sticky orphan-result flag.
module cipher_arbiter
  import cipher_pkg::*;
#(
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              crypto_ready,
  input  logic              a_vin,
  input  logic              a_tin,
  input  logic [DATA_W-1:0] a_din,
  output logic              a_rdy,
  input  logic              b_vin,
  input  logic              b_tin,
  input  logic [DATA_W-1:0] b_din,
  output logic              b_rdy,
  input  logic              cfg_vin,
  input  logic [DATA_W-1:0] cfg_din,
  output logic              cfg_rdy,
  output logic              core_vin,
  output logic [1:0]        core_tin,
  output logic [DATA_W-1:0] core_din,
  input  logic              core_vout,
  input  logic              core_tout,
  input  logic [DATA_W-1:0] core_dout,
  output logic              a_vout,
  output logic              a_tout,
  output logic [DATA_W-1:0] a_dout,
  output logic              b_vout,
  output logic              b_tout,
  output logic [DATA_W-1:0] b_dout,
  output logic              err
);

  localparam int CW = $clog2(TAG_DEPTH) + 1;

  logic          tag_full;
  logic          tag_empty;
  logic          tag_owner;
  logic [CW-1:0] tag_count;
  logic          tag_push;
  logic          tag_pop;
  logic          orphan;

  logic          prefer_b;   // round-robin: 1 means B wins the next A/B tie
  logic          open_ab;
  logic          grant_a;
  logic          grant_b;
  logic          grant_cfg;
  core_req_t     issue;

  // rst gates the combinational readies so every output is 0 during reset.
  // A pending IV load closes the A/B path so the core can drain.
  always_comb begin
    open_ab   = crypto_ready & ~rst & ~cfg_vin & ~tag_full;
    grant_a   = open_ab & a_vin & (~b_vin | ~prefer_b);
    grant_b   = open_ab & b_vin & (~a_vin |  prefer_b);
    // core_vin low covers the IV beat itself still sitting in the issue register.
    grant_cfg = crypto_ready & ~rst & cfg_vin & (tag_count == '0) & ~core_vin;
  end

  assign a_rdy   = grant_a;
  assign b_rdy   = grant_b;
  assign cfg_rdy = grant_cfg;

  assign tag_push = grant_a | grant_b;
  assign tag_pop  = core_vout & ~tag_empty;
  assign orphan   = core_vout &  tag_empty;

  tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push),
    .din   (grant_b),
    .pop   (tag_pop),
    .dout  (tag_owner),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  // Issue register towards the core; an idle beat is all zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue    <= '0;
      prefer_b <= 1'b0;
    end else begin
      issue <= '0;
      if (grant_cfg) begin
        issue <= '{vld: 1'b1, typ: CORE_IV, dat: cfg_din};
      end else if (grant_a) begin
        issue    <= '{vld: 1'b1, typ: req_type(a_tin), dat: a_din};
        prefer_b <= 1'b1;
      end else if (grant_b) begin
        issue    <= '{vld: 1'b1, typ: req_type(b_tin), dat: b_din};
        prefer_b <= 1'b0;
      end
    end
  end

  assign core_vin = issue.vld;
  assign core_tin = issue.typ;
  assign core_din = issue.dat;

  // Result demux: only the owner's outputs carry data, everything else stays 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vout <= 1'b0;
      a_tout <= 1'b0;
      a_dout <= '0;
      b_vout <= 1'b0;
      b_tout <= 1'b0;
      b_dout <= '0;
      err    <= 1'b0;
    end else begin
      a_vout <= 1'b0;
      a_tout <= 1'b0;
      a_dout <= '0;
      b_vout <= 1'b0;
      b_tout <= 1'b0;
      b_dout <= '0;
      if (tag_pop && tag_owner == OWNER_A) begin
        a_vout <= 1'b1;
        a_tout <= core_tout;
        a_dout <= core_dout;
      end
      if (tag_pop && tag_owner == OWNER_B) begin
        b_vout <= 1'b1;
        b_tout <= core_tout;
        b_dout <= core_dout;
      end
      if (orphan) err <= 1'b1;
    end
  end

endmodule
